mem_access_unit: RTL and testbench

- Memory-stage load/store unit of the MIPS datapath.
- Takes the effective address from the ALU (base + sign-extended offset) and the store data from the register file.
- Runs one data-memory transaction at a time over a req/gnt/rvalid bus.
- Returns word, halfword or byte load data, sign- or zero-extended to 32 bits, for writeback.

---
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid data-memory transaction at a time,
// with lane steering, byte enables and load extension. Optional macro: MEM_ALIGN_EXC_EN.
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        op_load,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        exc,
  output logic [31:0] badvaddr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        load_q, load_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [3:0]  be_calc;
  logic [31:0] wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Big-endian mirrors the lane index: byte k sits at lane 3-k.
  assign byte_lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
  assign half_lane = addr_q[1] ^ BIG_ENDIAN;

  always_comb begin
    be_calc   = 4'b1111;
    wdata_rep = wdata_q;
    case (size_q)
      2'b00: begin
        be_calc   = 4'b0001 << byte_lane;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_calc   = half_lane ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be_calc   = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  assign byte_sel = mem_rdata[{byte_lane, 3'b000} +: 8];
  assign half_sel = half_lane ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

`ifdef MEM_ALIGN_EXC_EN
  logic exc_q, exc_d;
  logic misalign_in;
  // Reserved size 11 is a word, so it shares the word alignment rule.
  assign misalign_in = ((op_size == 2'b01) && addr[0]) ||
                       (op_size[1] && (addr[1:0] != 2'b00));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 5'd0;
      rdata_q <= 32'd0;
`ifdef MEM_ALIGN_EXC_EN
      exc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
`ifdef MEM_ALIGN_EXC_EN
      exc_q   <= exc_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
`ifdef MEM_ALIGN_EXC_EN
    exc_d      = exc_q;
`endif
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 32'd0;
    resp_rd    = 5'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_be     = 4'b0000;
    mem_wdata  = 32'd0;
    exc        = 1'b0;
    badvaddr   = 32'd0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load_d  = op_load;
          size_d  = op_size;
          uns_d   = op_unsigned;
          addr_d  = addr;
          wdata_d = wdata;
          rd_d    = rd;
          rdata_d = 32'd0;
          state_d = REQ;
`ifdef MEM_ALIGN_EXC_EN
          exc_d = misalign_in;
          if (misalign_in) state_d = RESP;
`endif
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = ~load_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_be    = be_calc;
        mem_wdata = load_q ? 32'd0 : wdata_rep;
        if (mem_gnt) state_d = load_q ? WAIT : RESP;
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = rdata_q;
        resp_rd    = load_q ? rd_q : 5'd0;
`ifdef MEM_ALIGN_EXC_EN
        if (exc_q) begin
          exc       = 1'b1;
          badvaddr  = addr_q;
          resp_data = 32'd0;
          resp_rd   = 5'd0;
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed vectors checked with immediate assertions.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        op_load;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        exc;
  logic [31:0] badvaddr;

  int total = 0;
  int bad = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_load(op_load), .op_size(op_size), .op_unsigned(op_unsigned),
    .addr(addr), .wdata(wdata), .rd(rd),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .exc(exc), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op from IDLE, grants after gnt_delay REQ cycles, returns rdata in the
  // first WAIT cycle, and checks bus signals each REQ cycle plus the response timing.
  task automatic run_op(input string name, input logic ld, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] r, input logic [31:0] rdat, input int gnt_delay,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_data, input logic [4:0] exp_rd);
    check({name, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; op_load = ld; op_size = sz; op_unsigned = uns;
    addr = a; wdata = wd; rd = r; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= gnt_delay; i++) begin
      check({name, ".mem_req"}, {31'd0, mem_req}, 32'd1);
      check({name, ".mem_we"}, {31'd0, mem_we}, {31'd0, ~ld});
      check({name, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
      check({name, ".mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
      check({name, ".mem_wdata"}, mem_wdata, exp_wd);
      check({name, ".resp_valid_early"}, {31'd0, resp_valid}, 32'd0);
      mem_gnt = (i == gnt_delay);
      tick();
    end
    mem_gnt = 1'b0;
    if (ld) begin
      check({name, ".wait_mem_req"}, {31'd0, mem_req}, 32'd0);
      check({name, ".wait_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = rdat;
      tick();
      mem_rvalid = 1'b0;
    end
    check({name, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({name, ".resp_data"}, resp_data, exp_data);
    check({name, ".resp_rd"}, {27'd0, resp_rd}, {27'd0, exp_rd});
    check({name, ".resp_mem_req"}, {31'd0, mem_req}, 32'd0);
    check({name, ".resp_exc"}, {31'd0, exc}, 32'd0);
    $display("txn %s addr=%h be=%b data=%h rd=%0d", name, a, exp_be, resp_data, resp_rd);
    tick();
    check({name, ".after_valid"}, {31'd0, resp_valid}, 32'd0);
    check({name, ".after_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; op_load = 1'b0; op_size = 2'b00; op_unsigned = 1'b0;
    addr = 32'd0; wdata = 32'd0; rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    tick();
    tick();
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.resp_data", resp_data, 32'd0);
    check("rst.mem_req", {31'd0, mem_req}, 32'd0);
    check("rst.mem_be", {28'd0, mem_be}, 32'd0);
    check("rst.exc", {31'd0, exc}, 32'd0);
    check("rst.badvaddr", badvaddr, 32'd0);
    reset = 1'b0;
    tick();

    run_op("LB",  1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 5'd5, 32'h80FF_1234, 0,
           4'b1000, 32'h0, 32'hFFFF_FF80, 5'd5);
    run_op("LBU", 1'b1, 2'b00, 1'b1, 32'h0000_1001, 32'h0, 5'd6, 32'h80FF_1234, 0,
           4'b0010, 32'h0, 32'h0000_0012, 5'd6);
    run_op("LHU", 1'b1, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 5'd7, 32'hBEEF_0001, 0,
           4'b1100, 32'h0, 32'h0000_BEEF, 5'd7);
    run_op("LH",  1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 5'd8, 32'hBEEF_0001, 0,
           4'b1100, 32'h0, 32'hFFFF_BEEF, 5'd8);
    run_op("LHlo", 1'b1, 2'b01, 1'b0, 32'h0000_2000, 32'h0, 5'd9, 32'hBEEF_7001, 0,
           4'b0011, 32'h0, 32'h0000_7001, 5'd9);
    run_op("SB",  1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00AB, 5'd7, 32'h0, 4,
           4'b0010, 32'hABAB_ABAB, 32'h0, 5'd0);
    run_op("SHmis", 1'b0, 2'b01, 1'b0, 32'h0000_7003, 32'h5555_C0DE, 5'd3, 32'h0, 1,
           4'b1100, 32'hC0DE_C0DE, 32'h0, 5'd0);
    run_op("LWrsv", 1'b1, 2'b11, 1'b0, 32'h0000_8000, 32'h0, 5'd31, 32'hCAFE_F00D, 2,
           4'b1111, 32'h0, 32'hCAFE_F00D, 5'd31);

    // Reset while waiting for read data; the late rvalid must be dropped.
    req_valid = 1'b1; op_load = 1'b1; op_size = 2'b10; addr = 32'h0000_4000; rd = 5'd4;
    tick();
    req_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rstwait.mem_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    check("rstwait.ready", {31'd0, req_ready}, 32'd1);
    check("rstwait.resp_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    check("rstwait.late_rvalid", {31'd0, resp_valid}, 32'd0);
    check("rstwait.mem_req_idle", {31'd0, mem_req}, 32'd0);
    $display("txn LW addr=00004000 aborted by reset");
    run_op("LW",  1'b1, 2'b10, 1'b0, 32'h0000_4004, 32'h0, 5'd4, 32'h1234_5678, 0,
           4'b1111, 32'h0, 32'h1234_5678, 5'd4);

    // Back-to-back stores with req_valid held high.
    req_valid = 1'b1; op_load = 1'b0; op_size = 2'b10; addr = 32'h0000_6000;
    wdata = 32'h1111_1111; mem_gnt = 1'b1;
    tick();
    check("b2b.req1", {31'd0, mem_req}, 32'd1);
    check("b2b.ready_req", {31'd0, req_ready}, 32'd0);
    addr = 32'h0000_6004; wdata = 32'h2222_2222;
    tick();
    check("b2b.resp1", {31'd0, resp_valid}, 32'd1);
    check("b2b.mem_req_resp1", {31'd0, mem_req}, 32'd0);
    check("b2b.ready_resp", {31'd0, req_ready}, 32'd0);
    tick();
    check("b2b.idle_ready", {31'd0, req_ready}, 32'd1);
    check("b2b.idle_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    req_valid = 1'b0;
    check("b2b.req2", {31'd0, mem_req}, 32'd1);
    check("b2b.addr2", mem_addr, 32'h0000_6004);
    check("b2b.wdata2", mem_wdata, 32'h2222_2222);
    tick();
    mem_gnt = 1'b0;
    check("b2b.resp2", {31'd0, resp_valid}, 32'd1);
    check("b2b.mem_req_resp2", {31'd0, mem_req}, 32'd0);
    $display("txn SW x2 back-to-back addr=00006000/00006004");
    tick();
    check("b2b.done", {31'd0, resp_valid}, 32'd0);

`ifdef MEM_ALIGN_EXC_EN
    req_valid = 1'b1; op_load = 1'b1; op_size = 2'b10; addr = 32'h0000_5002; rd = 5'd9;
    mem_gnt = 1'b1;
    tick();
    req_valid = 1'b0; mem_gnt = 1'b0;
    check("exc.mem_req", {31'd0, mem_req}, 32'd0);
    check("exc.exc", {31'd0, exc}, 32'd1);
    check("exc.badvaddr", badvaddr, 32'h0000_5002);
    check("exc.resp_valid", {31'd0, resp_valid}, 32'd1);
    check("exc.resp_rd", {27'd0, resp_rd}, 32'd0);
    check("exc.resp_data", resp_data, 32'd0);
    $display("txn LW addr=00005002 exc=%0d", exc);
    tick();
    check("exc.clear", {31'd0, exc}, 32'd0);
    check("exc.ready", {31'd0, req_ready}, 32'd1);
`else
    run_op("LWmis", 1'b1, 2'b10, 1'b0, 32'h0000_5002, 32'h0, 5'd9, 32'h0BAD_F00D, 0,
           4'b1111, 32'h0, 32'h0BAD_F00D, 5'd9);
    check("noexc.badvaddr", badvaddr, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
